// File: rtl/bcd_clock_timer.sv
// bcd_clock_timer: BCD time-of-day clock / countdown timer with 12h display,
// validated nibble load path and an hh:mm alarm with auto-timeout.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   en                count enable (prescaler keeps running)
//   load, addr, d     nibble write: 0-7 time {hh,mm,ss,cc} LSN first, 8-11 alarm {mm,hh}
//   mode_down         0 = count up, 1 = countdown
//   h12               12h hour format on q[31:24]
//   alarm_en, alarm_ack  alarm arm / acknowledge
//   q                 {hh,mm,ss,cc} packed BCD
//   pm, p_secflash    hour >= 12, cc < 50
//   p_day, p_zero     day roll pulse (up), reached-zero pulse (down)
//   alarm             alarm level
module bcd_clock_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int ALARM_SEC = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        load,
  input  logic [3:0]  addr,
  input  logic [3:0]  d,
  input  logic        mode_down,
  input  logic        h12,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  output logic [31:0] q,
  output logic        pm,
  output logic        p_secflash,
  output logic        p_day,
  output logic        p_zero,
  output logic        alarm
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre;
  logic          tick;
  logic [7:0]    cc, ss, mm, hh, al_mm, al_hh;
  logic [7:0]    acnt;
  logic          hit_q;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Free-running prescaler; tick is high during its terminal count.
  assign tick = (pre == PW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PW'(1);
  end

  // A time-register write owns the cycle; alarm-register writes do not block counting.
  logic time_ld, upd;
  assign time_ld = load & ~addr[3];
  assign upd     = en & tick & ~time_ld;

  logic cw, sw, mw, hw, cz, sz, mz, all_zero;
  assign cw = (cc == 8'h99);
  assign sw = (ss == 8'h59);
  assign mw = (mm == 8'h59);
  assign hw = (hh == 8'h23);
  assign cz = (cc == 8'h00);
  assign sz = (ss == 8'h00);
  assign mz = (mm == 8'h00);
  assign all_zero = cz & sz & mz & (hh == 8'h00);

  logic [7:0] cc_n, ss_n, mm_n, hh_n;
  logic       day_n, zero_n;

  always_comb begin
    cc_n = cc; ss_n = ss; mm_n = mm; hh_n = hh;
    day_n = 1'b0; zero_n = 1'b0;
    if (!mode_down) begin
      cc_n = cw ? 8'h00 : bcd_inc(cc);
      if (cw)                ss_n = sw ? 8'h00 : bcd_inc(ss);
      if (cw & sw)           mm_n = mw ? 8'h00 : bcd_inc(mm);
      if (cw & sw & mw)      hh_n = hw ? 8'h00 : bcd_inc(hh);
      day_n = cw & sw & mw & hw;
    end else if (!all_zero) begin
      // Borrow chain; hh never underflows because all-zero holds.
      cc_n = cz ? 8'h99 : bcd_dec(cc);
      if (cz)                ss_n = sz ? 8'h59 : bcd_dec(ss);
      if (cz & sz)           mm_n = mz ? 8'h59 : bcd_dec(mm);
      if (cz & sz & mz)      hh_n = bcd_dec(hh);
      zero_n = ({hh_n, mm_n, ss_n, cc_n} == 32'h0);
    end
  end

  // One-second boundary crossed in either direction.
  logic sec_carry, hit;
  assign sec_carry = upd & (mode_down ? (cz & ~all_zero) : cw);
  assign hit = upd & ~mode_down & alarm_en & (ss_n == 8'h00) & (cc_n == 8'h00) &
               (mm_n == al_mm) & (hh_n == al_hh);

  // Write validation: BCD digit, minute/second tens <= 5, resulting hour <= 23.
  logic wr_ok;
  always_comb begin
    wr_ok = load & (d <= 4'd9);
    case (addr)
      4'd3, 4'd5, 4'd9: if (d > 4'd5) wr_ok = 1'b0;
      4'd6:  if (hh[7:4] == 4'd2 && d > 4'd3) wr_ok = 1'b0;
      4'd7:  if (d > 4'd2 || (d == 4'd2 && hh[3:0] > 4'd3)) wr_ok = 1'b0;
      4'd10: if (al_hh[7:4] == 4'd2 && d > 4'd3) wr_ok = 1'b0;
      4'd11: if (d > 4'd2 || (d == 4'd2 && al_hh[3:0] > 4'd3)) wr_ok = 1'b0;
      4'd12, 4'd13, 4'd14, 4'd15: wr_ok = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cc <= '0; ss <= '0; mm <= '0; hh <= '0;
      al_mm <= '0; al_hh <= '0;
      p_day <= 1'b0; p_zero <= 1'b0;
    end else begin
      p_day  <= upd & day_n;
      p_zero <= upd & zero_n;
      if (upd) begin
        cc <= cc_n; ss <= ss_n; mm <= mm_n; hh <= hh_n;
      end
      // Time writes and upd are exclusive, so this never collides with counting.
      if (wr_ok) begin
        case (addr)
          4'd0:  cc[3:0]    <= d;
          4'd1:  cc[7:4]    <= d;
          4'd2:  ss[3:0]    <= d;
          4'd3:  ss[7:4]    <= d;
          4'd4:  mm[3:0]    <= d;
          4'd5:  mm[7:4]    <= d;
          4'd6:  hh[3:0]    <= d;
          4'd7:  hh[7:4]    <= d;
          4'd8:  al_mm[3:0] <= d;
          4'd9:  al_mm[7:4] <= d;
          4'd10: al_hh[3:0] <= d;
          4'd11: al_hh[7:4] <= d;
          default: ;
        endcase
      end
    end
  end

  // Alarm: hit_q delays the rise by one cycle; a pending trigger beats ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q <= 1'b0; alarm <= 1'b0; acnt <= '0;
    end else begin
      hit_q <= hit;
      if (!alarm_en) alarm <= 1'b0;
      else if (hit_q) begin
        alarm <= 1'b1;
        acnt  <= '0;
      end else if (alarm_ack) alarm <= 1'b0;
      else if (alarm && sec_carry) begin
        if (acnt == 8'(ALARM_SEC - 1)) alarm <= 1'b0;
        else                           acnt  <= acnt + 8'd1;
      end
    end
  end

  // 12h display: 00 -> 12, 13..23 -> 01..11, internal hour untouched.
  logic [4:0] hbin, h12b;
  logic [7:0] hdisp;
  always_comb begin
    hbin = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
    h12b = hbin - 5'd12;
    if (!h12)                          hdisp = hh;
    else if (hh == 8'h00 || hh == 8'h12) hdisp = 8'h12;
    else if (hh > 8'h12)
      hdisp = (h12b >= 5'd10) ? {4'd1, h12b[3:0] - 4'd10} : {4'd0, h12b[3:0]};
    else                               hdisp = hh;
  end

  assign q          = {hdisp, mm, ss, cc};
  assign pm         = (hh >= 8'h12);
  assign p_secflash = (cc < 8'h50);

endmodule

// File: tb/tb_bcd_clock_timer.sv
// Scoreboard bench: an integer centisecond model predicts every cycle, a
// negedge monitor pops and compares all outputs.
module tb_bcd_clock_timer;
  localparam int CLK_HZ = 1000, TICK_HZ = 100, ALARM_SEC = 2;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DAY = 8_640_000;

  logic clk = 0, reset_n = 0, en = 0, load = 0, mode_down = 0, h12 = 0;
  logic alarm_en = 0, alarm_ack = 0;
  logic [3:0] addr = 0, d = 0;
  logic [31:0] q;
  logic pm, p_secflash, p_day, p_zero, alarm;

  bcd_clock_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ALARM_SEC(ALARM_SEC)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .addr(addr), .d(d),
    .mode_down(mode_down), .h12(h12), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .q(q), .pm(pm), .p_secflash(p_secflash), .p_day(p_day), .p_zero(p_zero), .alarm(alarm));

  always #5 clk = ~clk;

  typedef struct { int t; bit pd; bit pz; bit al; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  // Reference model state: time as centiseconds since midnight.
  int m_pc = 0, m_t = 0, m_ah = 0, m_am = 0, m_acnt = 0;
  bit m_al = 0, m_pend = 0, m_pd = 0, m_pz = 0;

  function automatic int wr_field(int f, int a, int dv, int maxv);
    int nv;
    nv = (a % 2 == 1) ? dv * 10 + f % 10 : (f / 10) * 10 + dv;
    return (dv <= 9 && nv <= maxv) ? nv : f;
  endfunction

  function automatic logic [7:0] bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  task automatic model_step();
    bit tick, sc, hit;
    int hh, mm, ss, cc;
    tick = (m_pc == DIV - 1);
    m_pc = (m_pc + 1) % DIV;
    m_pd = 0; m_pz = 0; sc = 0; hit = 0;
    if (load && addr < 8) begin
      hh = m_t / 360000; mm = (m_t / 6000) % 60; ss = (m_t / 100) % 60; cc = m_t % 100;
      case (int'(addr) / 2)
        0: cc = wr_field(cc, int'(addr), int'(d), 99);
        1: ss = wr_field(ss, int'(addr), int'(d), 59);
        2: mm = wr_field(mm, int'(addr), int'(d), 59);
        default: hh = wr_field(hh, int'(addr), int'(d), 23);
      endcase
      m_t = ((hh * 60 + mm) * 60 + ss) * 100 + cc;
    end else if (en && tick) begin
      if (!mode_down) begin
        m_t = (m_t + 1) % DAY;
        m_pd = (m_t == 0);
        sc = (m_t % 100 == 0);
        hit = alarm_en && (m_t % 6000 == 0) && (m_t / 360000 == m_ah) &&
              ((m_t / 6000) % 60 == m_am);
      end else if (m_t > 0) begin
        sc = (m_t % 100 == 0);
        m_t = m_t - 1;
        m_pz = (m_t == 0);
      end
    end
    if (load && addr >= 8 && addr <= 11) begin
      if (addr < 10) m_am = wr_field(m_am, int'(addr), int'(d), 59);
      else           m_ah = wr_field(m_ah, int'(addr), int'(d), 23);
    end
    if (!alarm_en) m_al = 0;
    else if (m_pend) begin m_al = 1; m_acnt = 0; end
    else if (alarm_ack) m_al = 0;
    else if (m_al && sc) begin
      m_acnt = m_acnt + 1;
      if (m_acnt == ALARM_SEC) m_al = 0;
    end
    m_pend = hit;
  endtask

  always @(posedge clk or negedge reset_n) begin
    exp_t e;
    if (!reset_n) begin
      m_pc = 0; m_t = 0; m_ah = 0; m_am = 0; m_acnt = 0;
      m_al = 0; m_pend = 0; m_pd = 0; m_pz = 0;
    end else model_step();
    e.t = m_t; e.pd = m_pd; e.pz = m_pz; e.al = m_al;
    sb.push_back(e);
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t actual=%h required=%h", n, $time, act, exp);
    end
  endtask

  // Monitor: only the newest prediction reflects the present DUT state.
  always @(negedge clk) begin
    exp_t e;
    int hh, dh;
    if (sb.size() > 0) begin
      while (sb.size() > 1) sb.delete(0);
      e = sb.pop_front();
      hh = e.t / 360000;
      dh = h12 ? ((hh % 12 == 0) ? 12 : hh % 12) : hh;
      chk("q", q, {bcd(dh), bcd((e.t / 6000) % 60), bcd((e.t / 100) % 60), bcd(e.t % 100)});
      chk("pm", 32'(pm), 32'(hh >= 12));
      chk("p_secflash", 32'(p_secflash), 32'(e.t % 100 < 50));
      chk("p_day", 32'(p_day), 32'(e.pd));
      chk("p_zero", 32'(p_zero), 32'(e.pz));
      chk("alarm", 32'(alarm), 32'(e.al));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(int a, int dv);
    load = 1; addr = 4'(a); d = 4'(dv);
    cyc(1);
    load = 0;
  endtask

  // Clear hour tens first so any target hour is reachable nibble by nibble.
  task automatic ld_time(int h, int m, int s, int c);
    wr(7, 0); wr(6, h % 10); wr(7, h / 10);
    wr(4, m % 10); wr(5, m / 10);
    wr(2, s % 10); wr(3, s / 10);
    wr(0, c % 10); wr(1, c / 10);
  endtask

  task automatic wait_model_alarm();
    for (int i = 0; i < 40 && !m_al; i++) cyc(1);
  endtask

  initial begin
    cyc(3);
    reset_n = 1;
    cyc(2);
    // Day roll in up mode.
    ld_time(23, 59, 59, 99);
    en = 1; cyc(25); en = 0;
    // Countdown to zero and hold.
    mode_down = 1;
    ld_time(0, 0, 1, 0);
    en = 1; cyc(DIV * 102 + 5); en = 0;
    mode_down = 0;
    // Rejected writes.
    ld_time(12, 34, 45, 67);
    wr(3, 6); wr(0, 10); wr(5, 7); wr(7, 3);
    ld_time(4, 0, 0, 0);
    wr(7, 2); cyc(2);
    ld_time(19, 0, 0, 0);
    wr(6, 5); cyc(2);
    // 12h display.
    h12 = 1;
    ld_time(0, 0, 0, 0);   cyc(2);
    ld_time(13, 5, 0, 0);  cyc(2);
    ld_time(12, 0, 0, 0);  cyc(2);
    ld_time(23, 59, 0, 0); cyc(2);
    h12 = 0;
    // Alarm with timeout.
    wr(8, 0); wr(9, 3); wr(10, 7); wr(11, 0); wr(9, 7);
    alarm_en = 1;
    ld_time(7, 29, 59, 99);
    en = 1; cyc(DIV * 215); en = 0;
    // Alarm with ack.
    ld_time(7, 29, 59, 99);
    en = 1; wait_model_alarm();
    cyc(3); alarm_ack = 1; cyc(1); alarm_ack = 0; cyc(10);
    en = 0;
    // Alarm cleared by disarm.
    ld_time(7, 29, 59, 98);
    en = 1; wait_model_alarm();
    cyc(2); alarm_en = 0; cyc(3); alarm_en = 1;
    // Alarm high again, then async reset between edges.
    en = 0;
    ld_time(7, 29, 59, 99);
    en = 1; wait_model_alarm();
    cyc(7);
    #3 reset_n = 0;
    cyc(2);
    reset_n = 1;
    cyc(3);
    // Randomised run near the day roll; alarm regs are 00:00 after reset.
    en = 0;
    ld_time(23, 59, 58, 0);
    for (int i = 0; i < 4000; i++) begin
      load      = ($urandom_range(0, 15) == 0);
      addr      = 4'($urandom_range(0, 15));
      d         = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      en        = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 299) == 0) mode_down = ~mode_down;
      h12       = 1'($urandom_range(0, 1));
      alarm_en  = ($urandom_range(0, 31) != 0);
      alarm_ack = ($urandom_range(0, 63) == 0);
      cyc(1);
    end
    load = 0; alarm_ack = 0;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
